// File: rtl/uart_tx_feeder.sv
// Buffered byte source for a UART transmitter: a FIFO feeds one byte per frame,
// holding start high for START_CYCLES and then enforcing a GAP_CYCLES frame gap.
module uart_tx_feeder #(
    parameter int D_WIDTH      = 8,
    parameter int DEPTH        = 16,
    parameter int START_CYCLES = 100,
    parameter int GAP_CYCLES   = 1200
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     en,
    input  logic                     s_valid,
    input  logic [D_WIDTH-1:0]       s_data,
    output logic                     s_ready,
    output logic                     start,
    output logic [D_WIDTH-1:0]       data_in,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_W   = AW + 1;
    localparam int MAX_CYC = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        GAP
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic                 start_q, start_d;
    logic [D_WIDTH-1:0]   data_q, data_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [D_WIDTH-1:0]   mem [DEPTH];

    logic push;
    logic pop;

    // Full is judged on registered occupancy only, so a same-cycle pop never opens a slot.
    assign s_ready = (count_q < CNT_W'(DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == IDLE) && en && (count_q != '0);

    assign start   = start_q;
    assign data_in = data_q;
    assign count   = count_q;
    assign busy    = (state_q != IDLE) || (count_q != '0);

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d  = state_q;
        cyc_d    = cyc_q;
        start_d  = start_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = mem[rd_ptr_q];
                    start_d = 1'b1;
                    cyc_d   = CW'(START_CYCLES - 1);
                    state_d = START;
                end
            end
            START: begin
                if (cyc_q == '0) begin
                    start_d = 1'b0;
                    cyc_d   = CW'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            GAP: begin
                // data_in stays put through the gap in case the UART samples late.
                if (cyc_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            start_q  <= start_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; cleared pointers and count make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= s_data;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffered byte source that sits directly upstream of the UART transmitter and drives its start / data_in inputs.
- Accepts bytes from a producer over a valid/ready handshake and stores them in an internal FIFO.
- Launches one UART frame per byte: holds start high for a fixed number of cycles, then waits a fixed frame gap before launching the next byte.
- Replaces hand-timed start pulses with deterministic, parameterised pacing.

Parameters:
- D_WIDTH, 8: byte width; matches the UART D_WIDTH.
- DEPTH, 16: FIFO entries; must be a power of 2 and at least 2.
- START_CYCLES, 100: clock cycles start is held high per frame; at least 1.
- GAP_CYCLES, 1200: cycles after start falls before the next launch is allowed; at least 1; covers the full UART frame.

Ports:
- clk, input, 1: system clock, same clock as the UART.
- arst_n, input, 1: asynchronous active-low reset.
- en, input, 1: launch enable; when 0, no new frame starts.
- s_valid, input, 1: producer byte valid.
- s_data, input, D_WIDTH: producer byte.
- s_ready, output, 1: FIFO can accept a byte.
- start, output, 1: to UART start.
- data_in, output, D_WIDTH: to UART data_in.
- busy, output, 1: frame in progress or FIFO non-empty.
- count, output, $clog2(DEPTH)+1: FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, arst_n).
- Reset values: start=0, data_in=0, s_ready=1, busy=0, count=0, state=IDLE. All FIFO pointers are cleared.
- Reset mid-frame:
  - start drops immediately (asynchronous).
  - Buffered bytes are discarded.
  - No partial-frame recovery.
- FIFO:
  - Write when s_valid && s_ready at a rising edge.
  - s_ready = (count < DEPTH), combinational from registered count.
  - A pop in the same cycle does not free a slot for a write while full, so a full FIFO never accepts.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count += write, -= pop. Simultaneous write and pop leaves count unchanged.
- FSM states: IDLE, START, GAP.
- IDLE:
  - If en && count != 0 at an edge: pop the FIFO head into the data_in register, set start=1, go to START, load the cycle counter with START_CYCLES-1.
  - Otherwise stay in IDLE.
- START:
  - start=1; data_in is held.
  - Counter decrements each cycle.
  - At 0: start=0, load GAP_CYCLES-1, go to GAP.
  - start is therefore high for exactly START_CYCLES cycles.
- GAP:
  - start=0; data_in is still held, because the UART may sample late.
  - At counter 0: go to IDLE.
  - The next launch occurs at the earliest on the following edge, so the minimum frame period is START_CYCLES+GAP_CYCLES+1 cycles.
- en:
  - Sampled only in IDLE.
  - Deasserting en during START or GAP does not abort the current frame.
- Latency: byte accepted at edge k into an empty FIFO with IDLE and en=1 → start registered high after edge k+1, with data_in equal to that byte.
- Ordering: strict FIFO order; no byte is dropped or duplicated.
- busy = (state != IDLE) || (count != 0), registered-state derived.
- data_in: retains the last transmitted byte in IDLE and changes only on a pop.
- Counter width: $clog2(max(START_CYCLES, GAP_CYCLES)+1) bits, with no overflow.

Test Plan (DEPTH=4, START_CYCLES=3, GAP_CYCLES=10, D_WIDTH=8 unless stated):
- Reset check: hold arst_n=0 → start=0, data_in=0x00, count=0, s_ready=1, busy=0. Release reset with no input → outputs unchanged for 50 cycles.
- Single byte: write 0x48 at edge k with en=1.
  - start=1 after edge k+1 for exactly 3 cycles; data_in=0x48.
  - start then low 10 cycles; busy=0 after edge k+14.
- Burst "Hi!": write 0x48, 0x69, 0x21 back-to-back.
  - Three start pulses, rising edges 14 cycles apart.
  - data_in sequence 0x48, 0x69, 0x21; count peaks at 2, then returns to 0.
- Full FIFO: en=0, write 6 bytes 0x01..0x06 with s_valid held.
  - s_ready=0 after the 4th accept; count=4; bytes 5 and 6 are not accepted.
  - Set en=1 → frames carry 0x01..0x04 in order, and s_ready returns to 1 after the first pop.
- en drop mid-frame: deassert en during START of byte 0xAA with 0xBB queued.
  - 0xAA frame completes, with a full 3-cycle start and 10-cycle gap.
  - No launch of 0xBB until en=1; 0xBB launches on the next edge.
- Reset mid-frame: assert arst_n=0 during START with 2 bytes queued → start=0 immediately, count=0. After release, no further start pulses occur.
